// File: rtl/picorv32_mem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the PicoRV32 native memory bus.
// Optional BUSY watchdog enabled by defining PICORV32_MEM_ARB_TIMEOUT_EN.
module picorv32_mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_rst_req,
  input  logic              r0_valid,
  input  logic              r0_instr,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  input  logic [3:0]        r0_wstrb,
  output logic              r0_ready,
  output logic [31:0]       r0_rdata,
  input  logic              r1_valid,
  input  logic              r1_instr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  input  logic [3:0]        r1_wstrb,
  output logic              r1_ready,
  output logic [31:0]       r1_rdata,
  output logic              mem_valid,
  output logic              mem_instr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              grant_id,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65536");
  end

  state_e              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                soft_pend_q, soft_pend_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_instr_q, mem_instr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_wstrb_q, mem_wstrb_d;
  logic                grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                r0_ready_q, r0_ready_d;
  logic                r1_ready_q, r1_ready_d;
  logic [31:0]         r0_rdata_q, r0_rdata_d;
  logic [31:0]         r1_rdata_q, r1_rdata_d;
  logic                timeout_err_q, timeout_err_d;
  logic                win_c;
  logic [31:0]         resp_data_c;
  logic                timeout_c;

`ifdef PICORV32_MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  // Counts BUSY cycles; zero in every other state so each grant starts fresh.
  always_comb begin
    cnt_d = 16'd0;
    if (state_q == ST_BUSY) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end

  assign timeout_c = (state_q == ST_BUSY) && (cnt_q == TO_LAST);
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    soft_pend_d   = soft_pend_q;
    mem_valid_d   = mem_valid_q;
    mem_instr_d   = mem_instr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wstrb_d   = mem_wstrb_q;
    grant_d       = grant_q;
    r0_ready_d    = 1'b0;
    r1_ready_d    = 1'b0;
    r0_rdata_d    = r0_rdata_q;
    r1_rdata_d    = r1_rdata_q;
    timeout_err_d = timeout_err_q;
    win_c         = (r0_valid && r1_valid) ? ~rr_ptr_q : r1_valid;
    resp_data_c   = mem_ready ? mem_rdata : 32'hDEAD_BEEF;

    unique case (state_q)
      ST_IDLE: begin
        if (soft_rst_req || soft_pend_q) begin
          // Local re-init takes the whole cycle; nobody is granted.
          rr_ptr_d      = 1'b0;
          timeout_err_d = 1'b0;
          soft_pend_d   = 1'b0;
        end else if (r0_valid || r1_valid) begin
          grant_d     = win_c;
          mem_valid_d = 1'b1;
          mem_instr_d = win_c ? r1_instr : r0_instr;
          mem_addr_d  = win_c ? r1_addr  : r0_addr;
          mem_wdata_d = win_c ? r1_wdata : r0_wdata;
          mem_wstrb_d = win_c ? r1_wstrb : r0_wstrb;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (soft_rst_req) soft_pend_d = 1'b1;
        if ((mem_ready && mem_valid_q) || timeout_c) begin
          mem_valid_d = 1'b0;
          rr_ptr_d    = grant_q;
          if (grant_q) begin
            r1_ready_d = 1'b1;
            r1_rdata_d = resp_data_c;
          end else begin
            r0_ready_d = 1'b1;
            r0_rdata_d = resp_data_c;
          end
          if (!mem_ready) timeout_err_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // No arbitration here so a valid still held during the ready pulse is not re-granted.
        if (soft_rst_req) soft_pend_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= 1'b0;
      soft_pend_q   <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_instr_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= 32'd0;
      mem_wstrb_q   <= 4'd0;
      grant_q       <= 1'b0;
      busy_q        <= 1'b0;
      r0_ready_q    <= 1'b0;
      r1_ready_q    <= 1'b0;
      r0_rdata_q    <= 32'd0;
      r1_rdata_q    <= 32'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      soft_pend_q   <= soft_pend_d;
      mem_valid_q   <= mem_valid_d;
      mem_instr_q   <= mem_instr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wstrb_q   <= mem_wstrb_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      r0_ready_q    <= r0_ready_d;
      r1_ready_q    <= r1_ready_d;
      r0_rdata_q    <= r0_rdata_d;
      r1_rdata_q    <= r1_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign r0_ready    = r0_ready_q;
  assign r1_ready    = r1_ready_q;
  assign r0_rdata    = r0_rdata_q;
  assign r1_rdata    = r1_rdata_q;
  assign mem_valid   = mem_valid_q;
  assign mem_instr   = mem_instr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Scoreboard bench for picorv32_mem_arbiter: directed requests, queued expectations, decoupled monitor.
`timescale 1ns/1ps
module tb_picorv32_mem_arbiter;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              soft_rst_req;
  logic              r0_valid, r0_instr, r0_ready;
  logic [ADDR_W-1:0] r0_addr;
  logic [31:0]       r0_wdata, r0_rdata;
  logic [3:0]        r0_wstrb;
  logic              r1_valid, r1_instr, r1_ready;
  logic [ADDR_W-1:0] r1_addr;
  logic [31:0]       r1_wdata, r1_rdata;
  logic [3:0]        r1_wstrb;
  logic              mem_valid, mem_instr, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [3:0]        mem_wstrb;
  logic              grant_id, busy, timeout_err;

  always #5 clk = ~clk;

  picorv32_mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .soft_rst_req(soft_rst_req),
    .r0_valid(r0_valid), .r0_instr(r0_instr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_wstrb(r0_wstrb), .r0_ready(r0_ready), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_instr(r1_instr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_wstrb(r1_wstrb), .r1_ready(r1_ready), .r1_rdata(r1_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic        id;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct packed {
    logic        id;
    logic [31:0] rdata;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   mem_lat = 3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic flag(input string name, input string act, input string req);
    n_total++;
    $display("FAIL %s: got %s, required %s", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_req(input logic id, input logic instr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    req_t r;
    r.id = id; r.instr = instr; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
    exp_req_q.push_back(r);
  endtask

  task automatic expect_txn(input logic id, input logic instr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb,
                            input logic [31:0] rdata);
    rsp_t s;
    push_req(id, instr, addr, wdata, wstrb);
    s.id = id; s.rdata = rdata;
    exp_rsp_q.push_back(s);
  endtask

  task automatic set_req(input logic id, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    if (id) begin
      r1_instr = instr; r1_addr = addr; r1_wdata = wdata; r1_wstrb = wstrb; r1_valid = 1'b1;
    end else begin
      r0_instr = instr; r0_addr = addr; r0_wdata = wdata; r0_wstrb = wstrb; r0_valid = 1'b1;
    end
  endtask

  task automatic drop(input logic id);
    if (id) r1_valid = 1'b0;
    else    r0_valid = 1'b0;
  endtask

  // Returns #1 into the cycle where the requester's ready is high.
  task automatic wait_ready(input logic id);
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      tick(1);
      got = id ? r1_ready : r0_ready;
    end
    if (!got) flag(id ? "wait_r1_ready" : "wait_r0_ready", "timeout", "ready pulse");
  endtask

  task automatic do_req(input logic id, input logic instr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
    set_req(id, instr, addr, wdata, wstrb);
    wait_ready(id);
    drop(id);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, 64'({r0_ready, r1_ready, mem_valid, mem_instr, grant_id, busy,
                            timeout_err, mem_wstrb}), 64'd0);
    chk({tag, "_r0_rdata"}, 64'(r0_rdata), 64'd0);
    chk({tag, "_r1_rdata"}, 64'(r1_rdata), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  function automatic logic [31:0] mem_table(input logic [31:0] addr);
    if (addr == 32'h100) return 32'h1234_5678;
    return {addr[15:0], 16'hBEEF};
  endfunction

  // Memory model: raises mem_ready mem_lat cycles after mem_valid is first seen.
  initial begin
    int cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (mem_valid && !reset) begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_table(mem_addr);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: checks each new memory request and each ready pulse against the queues.
  initial begin
    logic prev_mv = 1'b0;
    req_t cur = '0;
    rsp_t exp_s;
    forever begin
      @(negedge clk);
      if (mem_valid && !prev_mv) begin
        if (exp_req_q.size() == 0) begin
          flag("unexpected_mem_valid", "request", "none");
        end else begin
          cur = exp_req_q.pop_front();
          chk("req_grant_id", 64'(grant_id), 64'(cur.id));
          chk("req_addr", 64'(mem_addr), 64'(cur.addr));
          chk("req_wdata", 64'(mem_wdata), 64'(cur.wdata));
          chk("req_wstrb_instr", 64'({mem_wstrb, mem_instr}), 64'({cur.wstrb, cur.instr}));
        end
      end else if (mem_valid) begin
        chk("req_hold", 64'({mem_instr, mem_wstrb, mem_addr}), 64'({cur.instr, cur.wstrb, cur.addr}));
        chk("req_hold_busy", 64'({busy, mem_wdata}), 64'({1'b1, cur.wdata}));
      end
      prev_mv = mem_valid;
      if (r0_ready || r1_ready) begin
        if (exp_rsp_q.size() == 0) begin
          flag("unexpected_ready", "ready pulse", "none");
        end else begin
          exp_s = exp_rsp_q.pop_front();
          chk("rsp_ready_pair", 64'({r1_ready, r0_ready}), exp_s.id ? 64'd2 : 64'd1);
          chk("rsp_rdata", 64'(exp_s.id ? r1_rdata : r0_rdata), 64'(exp_s.rdata));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; soft_rst_req = 1'b0;
    r0_valid = 1'b0; r0_instr = 1'b0; r0_addr = '0; r0_wdata = '0; r0_wstrb = '0;
    r1_valid = 1'b0; r1_instr = 1'b0; r1_addr = '0; r1_wdata = '0; r1_wstrb = '0;
    tick(2);
    check_reset_outputs("reset");
    reset = 1'b0;
    tick(1);

    // Single r0 read: one-cycle grant latency, memory answers 3 cycles later.
    expect_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 32'h1234_5678);
    set_req(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
    tick(1);
    chk("t1_latency_busy", 64'({mem_valid, busy}), 64'd3);
    wait_ready(1'b0);
    drop(1'b0);
    tick(2);

    // Both requesters always valid after reset: r1, r0, r1, r0.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    expect_txn(1'b1, 1'b0, 32'h2000, 32'hAAAA_5555, 4'hF, 32'h2000_BEEF);
    expect_txn(1'b0, 1'b1, 32'h1000, 32'h1111_1111, 4'h3, 32'h1000_BEEF);
    expect_txn(1'b1, 1'b1, 32'h2008, 32'h0000_0000, 4'h0, 32'h2008_BEEF);
    expect_txn(1'b0, 1'b0, 32'h1004, 32'h2222_2222, 4'h0, 32'h1004_BEEF);
    fork
      begin
        do_req(1'b1, 1'b0, 32'h2000, 32'hAAAA_5555, 4'hF);
        tick(1);
        do_req(1'b1, 1'b1, 32'h2008, 32'h0000_0000, 4'h0);
      end
      begin
        do_req(1'b0, 1'b1, 32'h1000, 32'h1111_1111, 4'h3);
        tick(1);
        do_req(1'b0, 1'b0, 32'h1004, 32'h2222_2222, 4'h0);
      end
    join
    tick(2);

    // Soft reset during an r1 write: access completes, then a blocked IDLE cycle clears rr_ptr.
    mem_lat = 4;
    expect_txn(1'b1, 1'b0, 32'h200, 32'hCAFE_F00D, 4'hF, 32'h0200_BEEF);
    expect_txn(1'b1, 1'b1, 32'h204, 32'h0, 4'h0, 32'h0204_BEEF);
    expect_txn(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 32'h0300_BEEF);
    set_req(1'b1, 1'b0, 32'h200, 32'hCAFE_F00D, 4'hF);
    tick(2);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    chk("soft_mem_valid_held", 64'(mem_valid), 64'd1);
    wait_ready(1'b1);
    drop(1'b1);
    set_req(1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
    tick(1);
    set_req(1'b1, 1'b1, 32'h204, 32'h0, 4'h0);
    chk("soft_idle_mem_valid", 64'(mem_valid), 64'd0);
    tick(1);
    chk("soft_no_grant", 64'(mem_valid), 64'd0);
    tick(1);
    chk("soft_regrant_r1", 64'({mem_valid, grant_id}), 64'd3);
    wait_ready(1'b1);
    drop(1'b1);
    wait_ready(1'b0);
    drop(1'b0);
    tick(2);
    mem_lat = 3;

    // Async reset in BUSY: outputs clear immediately and no ready pulse follows.
    mem_lat = 100000;
    push_req(1'b0, 1'b0, 32'h400, 32'h0, 4'h0);
    set_req(1'b0, 1'b0, 32'h400, 32'h0, 4'h0);
    tick(3);
    chk("rst_pre_busy", 64'({mem_valid, busy}), 64'd3);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_busy");
    drop(1'b0);
    tick(2);
    mem_lat = 3;
    reset = 1'b0;
    expect_txn(1'b1, 1'b0, 32'h600, 32'h6666_0000, 4'hC, 32'h0600_BEEF);
    expect_txn(1'b0, 1'b0, 32'h500, 32'h5555_0000, 4'h1, 32'h0500_BEEF);
    fork
      do_req(1'b0, 1'b0, 32'h500, 32'h5555_0000, 4'h1);
      do_req(1'b1, 1'b0, 32'h600, 32'h6666_0000, 4'hC);
    join
    tick(2);

    // Stale valid held through RESP must not be re-granted.
    expect_txn(1'b0, 1'b0, 32'h700, 32'h0, 4'h0, 32'h0700_BEEF);
    set_req(1'b0, 1'b0, 32'h700, 32'h0, 4'h0);
    wait_ready(1'b0);
    tick(1);
    drop(1'b0);
    chk("stale_idle_mem_valid", 64'(mem_valid), 64'd0);
    tick(1);
    chk("stale_next_mem_valid", 64'(mem_valid), 64'd0);
    tick(2);

    // Illegal valid drop in BUSY: access still completes with a ready pulse.
    expect_txn(1'b1, 1'b0, 32'h800, 32'h0000_0005, 4'h1, 32'h0800_BEEF);
    set_req(1'b1, 1'b0, 32'h800, 32'h0000_0005, 4'h1);
    tick(2);
    drop(1'b1);
    wait_ready(1'b1);
    tick(2);
    chk("r0_rdata_hold", 64'(r0_rdata), 64'h0700_BEEF);
    chk("timeout_err_idle", 64'(timeout_err), 64'd0);

`ifdef PICORV32_MEM_ARB_TIMEOUT_EN
    begin
      int cyc = 0;
      bit got = 1'b0;
      mem_lat = 100000;
      expect_txn(1'b0, 1'b0, 32'h900, 32'h0, 4'h0, 32'hDEAD_BEEF);
      set_req(1'b0, 1'b0, 32'h900, 32'h0, 4'h0);
      tick(1);
      for (int i = 0; i < 50 && !got; i++) begin
        tick(1);
        cyc++;
        got = r0_ready;
      end
      drop(1'b0);
      chk("to_busy_cycles", 64'(cyc), 64'd8);
      chk("to_flags", 64'({timeout_err, mem_valid}), 64'd2);
      tick(3);
      chk("to_sticky", 64'(timeout_err), 64'd1);
      soft_rst_req = 1'b1;
      tick(1);
      soft_rst_req = 1'b0;
      chk("to_soft_clear", 64'(timeout_err), 64'd0);
      mem_lat = 3;
      tick(2);
    end
`endif

    tick(5);
    chk("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
    chk("rsp_queue_empty", 64'(exp_rsp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
